type_decoder_pipe: RTL and testbench

- Registered decode stage for the RV32I pipeline. It replaces the purely combinational opcode-to-type decode used by the single-cycle CPU.
- Accepts fetched instructions on a valid/ready interface and classifies each opcode into a one-hot type vector, including an illegal class.
- Extracts register and function fields.
- A two-entry skid buffer gives full throughput with a registered in_ready. Sits between IF and ID/EX; flushable on branch redirect.

---
 rtl/type_decoder_pkg.sv | 39 +++
 rtl/opcode_classifier.sv | 34 +++
 rtl/type_decoder_pipe.sv | 159 +++++++++++++++
 tb/tb_type_decoder_pipe.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/type_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : type_decoder_pkg
//  Brief    : Shared opcode constants and one-hot type-vector bit indices
//             for the RV32I registered decode stage.
//  Revision : 1.0 - initial release
// ============================================================================
package type_decoder_pkg;

  // Width of the one-hot instruction-type vector
  localparam int NTYPES = 10;

  // RV32I major opcodes (instr[6:0]) recognised by the decoder
  localparam logic [6:0] OPC_R      = 7'h33;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  // Bit position of each class inside the one-hot type vector
  typedef enum logic [3:0] {
    T_R       = 4'd0,
    T_I_LW    = 4'd1,
    T_I_ADDI  = 4'd2,
    T_I_JALR  = 4'd3,
    T_S       = 4'd4,
    T_SB      = 4'd5,
    T_U_AUIPC = 4'd6,
    T_U_LUI   = 4'd7,
    T_UJ      = 4'd8,
    T_ILLEGAL = 4'd9
  } instr_type_e;

endpackage : type_decoder_pkg
`default_nettype wire

// File: rtl/opcode_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : opcode_classifier
//  Brief    : Combinational opcode -> one-hot type vector. Every opcode not
//             in the RV32I subset maps to the illegal class, so exactly one
//             output bit is always set.
//  Revision : 1.0 - initial release
// ============================================================================
module opcode_classifier
  import type_decoder_pkg::*;
(
  input  logic [6:0]        i_opcode,
  output logic [NTYPES-1:0] o_type
);

  // One-hot class select; default arm catches every unknown opcode
  always_comb begin
    o_type = '0;
    case (i_opcode)
      OPC_R:      o_type[T_R]       = 1'b1;
      OPC_LOAD:   o_type[T_I_LW]    = 1'b1;
      OPC_OPIMM:  o_type[T_I_ADDI]  = 1'b1;
      OPC_JALR:   o_type[T_I_JALR]  = 1'b1;
      OPC_STORE:  o_type[T_S]       = 1'b1;
      OPC_BRANCH: o_type[T_SB]      = 1'b1;
      OPC_AUIPC:  o_type[T_U_AUIPC] = 1'b1;
      OPC_LUI:    o_type[T_U_LUI]   = 1'b1;
      OPC_JAL:    o_type[T_UJ]      = 1'b1;
      default:    o_type[T_ILLEGAL] = 1'b1;
    endcase
  end

endmodule : opcode_classifier
`default_nettype wire

// File: rtl/type_decoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : type_decoder_pipe
//  Brief    : Registered RV32I decode stage between IF and ID/EX. Each beat
//             is classified on entry and stored with its decode in a two-entry
//             (main + skid) buffer, giving full throughput with a registered
//             in_ready. Flush drops all buffered beats.
//  Options  : TYPE_DECODER_TRAP_EN - delivering an illegal beat pulses trap
//             for one cycle and halts intake until the next flush.
//  Revision : 1.0 - initial release
// ============================================================================
module type_decoder_pipe #(
  parameter int ILEN   = 32,
  parameter int PC_W   = 32,
  parameter int NTYPES = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ILEN-1:0]   in_instr,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ILEN-1:0]   out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [NTYPES-1:0] out_type,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [2:0]        out_funct3,
  output logic [6:0]        out_funct7,
  output logic              trap
);

  import type_decoder_pkg::*;

  // Decode of the incoming word, stored alongside it on accept
  logic [NTYPES-1:0] w_in_type;

  opcode_classifier u_classifier (
    .i_opcode (in_instr[6:0]),
    .o_type   (w_in_type)
  );

  logic              r_main_valid;
  logic [ILEN-1:0]   r_main_instr;
  logic [PC_W-1:0]   r_main_pc;
  logic [NTYPES-1:0] r_main_type;
  logic              r_skid_valid;
  logic [ILEN-1:0]   r_skid_instr;
  logic [PC_W-1:0]   r_skid_pc;
  logic [NTYPES-1:0] r_skid_type;
  logic              r_in_ready;
  logic              r_halt;
  logic              r_trap;

  logic w_accept;
  logic w_deliver;
  logic w_main_free;
  logic w_main_valid_nxt;
  logic w_skid_valid_nxt;
  logic w_halt_nxt;
  logic w_trap_nxt;

  assign w_accept  = in_valid && r_in_ready;
  assign w_deliver = r_main_valid && out_ready;

`ifdef TYPE_DECODER_TRAP_EN
  // An illegal beat leaving main raises a one-cycle trap and freezes intake
  assign w_trap_nxt = w_deliver && r_main_type[T_ILLEGAL];
  assign w_halt_nxt = r_halt || w_trap_nxt;
`else
  assign w_trap_nxt = 1'b0;
  assign w_halt_nxt = 1'b0;
`endif

  // Occupancy update: main refills from skid first, then from the input
  always_comb begin
    w_main_free      = !r_main_valid || w_deliver;
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    if (w_main_free) begin
      w_main_valid_nxt = r_skid_valid || w_accept;
      w_skid_valid_nxt = r_skid_valid && w_accept;
    end else if (w_accept) begin
      w_skid_valid_nxt = 1'b1;
    end
  end

  // Buffer state, payload movement and registered ready; reset beats flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_main_instr <= '0;
      r_main_pc    <= '0;
      r_main_type  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_type  <= '0;
      r_in_ready   <= 1'b1;
      r_halt       <= 1'b0;
      r_trap       <= 1'b0;
    end else if (flush) begin
      // Payload may go stale, but the type vector must read empty
      r_main_valid <= 1'b0;
      r_main_type  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_type  <= '0;
      r_in_ready   <= 1'b1;
      r_halt       <= 1'b0;
      r_trap       <= 1'b0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_halt       <= w_halt_nxt;
      r_trap       <= w_trap_nxt;
      r_in_ready   <= !w_skid_valid_nxt && !w_halt_nxt;

      if (w_main_free) begin
        if (r_skid_valid) begin
          r_main_instr <= r_skid_instr;
          r_main_pc    <= r_skid_pc;
          r_main_type  <= r_skid_type;
        end else if (w_accept) begin
          r_main_instr <= in_instr;
          r_main_pc    <= in_pc;
          r_main_type  <= w_in_type;
        end else begin
          // Main drains empty: keep no type bit set while invalid
          r_main_type  <= '0;
        end
      end

      // Input lands in skid unless it went straight into an empty main
      if (w_accept && (!w_main_free || r_skid_valid)) begin
        r_skid_instr <= in_instr;
        r_skid_pc    <= in_pc;
        r_skid_type  <= w_in_type;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_main_valid;
  assign out_instr  = r_main_instr;
  assign out_pc     = r_main_pc;
  assign out_type   = r_main_type;
  assign out_rd     = r_main_instr[11:7];
  assign out_rs1    = r_main_instr[19:15];
  assign out_rs2    = r_main_instr[24:20];
  assign out_funct3 = r_main_instr[14:12];
  assign out_funct7 = r_main_instr[31:25];
  assign trap       = r_trap;

endmodule : type_decoder_pipe
`default_nettype wire

// File: tb/tb_type_decoder_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_type_decoder_pipe
//  Brief    : Self-checking bench for type_decoder_pipe. A negedge monitor
//             keeps a reference queue of accepted beats and logs every
//             delivered beat; scenario tasks compare against it.
//  Options  : TYPE_DECODER_TRAP_EN - enables trap/halt expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_type_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [9:0]  out_type;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic        trap;

  type_decoder_pipe #(.ILEN(32), .PC_W(32), .NTYPES(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_type   (out_type),
    .out_rd     (out_rd),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_funct3 (out_funct3),
    .out_funct7 (out_funct7),
    .trap       (trap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } beat_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [9:0]  typ;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } obs_t;

  // Legal opcodes in type-vector bit order; anything else is bit 9
  logic [6:0] opc_tab [9] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23,
                              7'h63, 7'h17, 7'h37, 7'h6F};

  beat_t pend[$];
  beat_t exp_q[$];
  obs_t  got_q[$];
  int    bad_onehot = 0;
  int    bad_stable = 0;
  int    bad_extra  = 0;
  int    checks     = 0;
  int    failures   = 0;

  function automatic logic [9:0] ref_type(input logic [31:0] instr);
    int idx;
    idx = 9;
    for (int i = 0; i < 9; i++)
      if (opc_tab[i] == instr[6:0]) idx = i;
    return 10'b1 << idx;
  endfunction

  function automatic logic [31:0] rand_instr(input bit legal_only);
    logic [31:0] r;
    logic [6:0]  opc;
    r = $urandom();
    if (!legal_only && $urandom_range(0, 4) == 0) opc = 7'($urandom());
    else opc = opc_tab[$urandom_range(0, 8)];
    return {r[31:7], opc};
  endfunction

  // Reference scoreboard: handshakes are judged just before the next edge
  logic hold_v = 1'b0;
  obs_t hold_o;
  always @(negedge clk) begin
    obs_t o;
    o = '{out_instr, out_pc, out_type, out_rd, out_rs1, out_rs2, out_funct3, out_funct7};
    if (!rst_n || flush) begin
      pend.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v && (!out_valid || o !== hold_o)) bad_stable++;
      if (out_valid && $countones(out_type) != 1) bad_onehot++;
      if (out_valid && out_ready) begin
        if (pend.size() == 0) bad_extra++;
        else begin
          exp_q.push_back(pend.pop_front());
          got_q.push_back(o);
        end
      end
      if (in_valid && in_ready) pend.push_back('{in_instr, in_pc});
      hold_v = out_valid && !out_ready;
      hold_o = o;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_type !== '0 || trap !== 1'b0 ||
        out_instr !== '0 || out_pc !== '0) begin
      failures++;
      $display("FAIL reset_hold: valid=%b ready=%b type=%b trap=%b instr=%h pc=%h required 0 1 0 0 0 0",
               out_valid, in_ready, out_type, trap, out_instr, out_pc);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_type !== '0 || trap !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: valid=%b ready=%b type=%b trap=%b required 0 1 0 0",
               out_valid, in_ready, out_type, trap);
    end
  endtask

  task automatic test_stream();
    logic [6:0]  ops [10] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h17, 7'h37, 7'h6F, 7'h00};
    logic [31:0] r;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      r = $urandom();
      in_valid = 1'b1;
      in_instr = {r[31:7], ops[k]};
      in_pc    = 32'h1000 + 32'(4 * k);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_instr !== in_instr ||
          out_pc !== in_pc || out_type !== (10'b1 << k)) begin
        failures++;
        $display("FAIL stream[%0d]: valid=%b ready=%b instr=%h pc=%h type=%b required 1 1 %h %h %b",
                 k, out_valid, in_ready, out_instr, out_pc, out_type, in_instr, in_pc, 10'b1 << k);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_type !== '0) begin
      failures++;
      $display("FAIL stream_drain: valid=%b type=%b required 0 0", out_valid, out_type);
    end
    // The last streamed opcode is illegal; clear any halt it may cause
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] b [3];
    int start;
    logic acc;
    start = got_q.size();
    for (int i = 0; i < 3; i++) b[i] = rand_instr(1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr = b[0]; in_pc = 32'h2000;
    @(posedge clk); #1;
    in_instr = b[1]; in_pc = 32'h2004;
    @(posedge clk); #1;
    in_instr = b[2]; in_pc = 32'h2008;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full: in_ready=%b required 0", in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_instr !== b[0] || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_hold: valid=%b instr=%h ready=%b required 1 %h 0", out_valid, out_instr, in_ready, b[0]);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (got_q.size() - start) < 3; c++) begin
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() - start != 3) begin
      failures++;
      $display("FAIL bp_count: delivered=%0d required 3", got_q.size() - start);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[start+i].instr !== b[i] || got_q[start+i].typ !== ref_type(b[i])) begin
          failures++;
          $display("FAIL bp_order[%0d]: instr=%h type=%b required %h %b",
                   i, got_q[start+i].instr, got_q[start+i].typ, b[i], ref_type(b[i]));
        end
      end
    end
  endtask

  task automatic test_flush();
    int n0;
    logic [31:0] d;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr = rand_instr(1'b1); in_pc = 32'h3000;
    @(posedge clk); #1;
    in_instr = rand_instr(1'b1); in_pc = 32'h3004;
    @(posedge clk); #1;
    in_instr = rand_instr(1'b1); in_pc = 32'h3008;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_pre: valid=%b ready=%b required 1 0", out_valid, in_ready);
    end
    n0 = got_q.size();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_type !== '0) begin
      failures++;
      $display("FAIL flush: valid=%b ready=%b type=%b required 0 1 0", out_valid, in_ready, out_type);
    end
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || got_q.size() != n0) begin
      failures++;
      $display("FAIL flush_discard: valid=%b delivered=%0d required 0 0", out_valid, got_q.size() - n0);
    end
    d = rand_instr(1'b1);
    in_valid = 1'b1; in_instr = d; in_pc = 32'h3100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (got_q.size() != n0 + 1 || got_q[n0].instr !== d) begin
      failures++;
      $display("FAIL flush_resume: delivered=%0d required 1 (beat %h)", got_q.size() - n0, d);
    end
  endtask

  task automatic test_random();
    int   start, sent, cyc;
    logic acc;
    bit   legal_only;
`ifdef TYPE_DECODER_TRAP_EN
    legal_only = 1'b1;
`else
    legal_only = 1'b0;
`endif
    start = got_q.size();
    sent = 0;
    cyc  = 0;
    in_valid = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) sent++;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_instr = rand_instr(legal_only);
        in_pc    = $urandom();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && out_valid === 1'b1; c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (sent != 1000 || got_q.size() - start != 1000 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rand_count: sent=%0d delivered=%0d valid=%b required 1000 1000 0",
               sent, got_q.size() - start, out_valid);
    end
    for (int i = start; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].instr !== exp_q[i].instr || got_q[i].pc !== exp_q[i].pc ||
          got_q[i].typ !== ref_type(exp_q[i].instr) ||
          got_q[i].rd !== exp_q[i].instr[11:7] || got_q[i].rs1 !== exp_q[i].instr[19:15] ||
          got_q[i].rs2 !== exp_q[i].instr[24:20] || got_q[i].f3 !== exp_q[i].instr[14:12] ||
          got_q[i].f7 !== exp_q[i].instr[31:25]) begin
        failures++;
        $display("FAIL rand_beat[%0d]: instr=%h pc=%h type=%b required %h %h %b",
                 i - start, got_q[i].instr, got_q[i].pc, got_q[i].typ,
                 exp_q[i].instr, exp_q[i].pc, ref_type(exp_q[i].instr));
      end
    end
    checks++;
    if (bad_onehot != 0 || bad_stable != 0 || bad_extra != 0) begin
      failures++;
      $display("FAIL protocol: onehot_err=%0d stable_err=%0d extra_beats=%0d required 0 0 0",
               bad_onehot, bad_stable, bad_extra);
    end
  endtask

  task automatic test_illegal();
    int start;
    logic [31:0] a, b;
    logic [31:0] r;
    start = got_q.size();
    r = $urandom();
    a = {r[31:7], 7'h7F};
    b = {r[31:7], 7'h33};
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = a; in_pc = 32'h4000;
    @(posedge clk); #1;
    checks++;
    if (trap !== 1'b0 || out_type !== 10'b10_0000_0000) begin
      failures++;
      $display("FAIL ill_entry: trap=%b type=%b required 0 1000000000", trap, out_type);
    end
    in_instr = b; in_pc = 32'h4004;
    @(posedge clk); #1;
`ifdef TYPE_DECODER_TRAP_EN
    checks++;
    if (trap !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL trap_pulse: trap=%b ready=%b required 1 0", trap, in_ready);
    end
    in_instr = rand_instr(1'b1); in_pc = 32'h4008;
    @(posedge clk); #1;
    checks++;
    if (trap !== 1'b0) begin
      failures++;
      $display("FAIL trap_once: trap=%b required 0", trap);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_hold: ready=%b valid=%b required 0 0", in_ready, out_valid);
    end
    in_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL halt_clear: ready=%b required 1", in_ready);
    end
`else
    in_valid = 1'b0;
    checks++;
    if (trap !== 1'b0 || in_ready !== 1'b1 || out_type !== 10'b00_0000_0001) begin
      failures++;
      $display("FAIL ill_pass: trap=%b ready=%b type=%b required 0 1 0000000001", trap, in_ready, out_type);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (trap !== 1'b0) begin
      failures++;
      $display("FAIL no_trap: trap=%b required 0", trap);
    end
`endif
    checks++;
    if (got_q.size() - start != 2 || got_q[start].instr !== a || got_q[start].typ !== 10'b10_0000_0000 ||
        got_q[start+1].instr !== b || got_q[start+1].typ !== 10'b00_0000_0001) begin
      failures++;
      $display("FAIL ill_sequence: delivered=%0d required 2 (%h illegal, %h r-type)",
               got_q.size() - start, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_flush();
    test_random();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_type_decoder_pipe
`default_nettype wire
